// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate formats, issue payload.
package decode_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        we;
    logic        illegal;
  } dec_pl_t;

  function automatic fmt_e opc_fmt(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC:            return FMT_U;
      OPC_JAL:                       return FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: return FMT_I;
      OPC_STORE:                     return FMT_S;
      OPC_BRANCH:                    return FMT_B;
      OPC_OP:                        return FMT_R;
      default:                       return FMT_NONE;
    endcase
  endfunction

  // R-type and unknown opcodes carry no immediate.
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input fmt_e f);
    case (f)
      FMT_I:   return {{20{i[31]}}, i[31:20]};
      FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   return {i[31:12], 12'b0};
      FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction
endpackage

// File: rtl/scoreboard.sv
// 32-entry busy-bit scoreboard; x0 never busy, a set beats a same-cycle clear.
module scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set_en,
  input  logic [4:0] i_set_idx,
  input  logic       i_clr_a_en,
  input  logic [4:0] i_clr_a_idx,
  input  logic       i_clr_b_en,
  input  logic [4:0] i_clr_b_idx,
  input  logic [4:0] i_q1_idx,
  input  logic [4:0] i_q2_idx,
  output logic       o_q1_busy,
  output logic       o_q2_busy
);
  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_a_en) w_busy_nxt[i_clr_a_idx] = 1'b0;
    if (i_clr_b_en) w_busy_nxt[i_clr_b_idx] = 1'b0;
    if (i_set_en)   w_busy_nxt[i_set_idx]   = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  assign o_q1_busy = (i_q1_idx != 5'd0) && r_busy[i_q1_idx];
  assign o_q2_busy = (i_q2_idx != 5'd0) && r_busy[i_q2_idx];
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with scoreboard interlock and one-entry issue register.
// Optional macro DECODE_WB_BYPASS_EN forwards wb_data to a source that retires this cycle.
module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [5:0]  rf_reg_a,
  output logic [5:0]  rf_reg_b,
  input  logic [31:0] rf_data_a,
  input  logic [31:0] rf_data_b,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
`ifdef DECODE_WB_BYPASS_EN
  input  logic [31:0] wb_data,
`endif
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic        out_we,
  output logic        out_illegal
);
  logic [6:0]  w_opc;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  fmt_e        w_fmt;
  logic        w_use1, w_use2, w_we;
  logic        w_busy1, w_busy2, w_byp1, w_byp2;
  logic        w_haz, w_acc;
  logic [31:0] w_v1, w_v2;
  dec_pl_t     w_pl, r_pl;
  logic        r_valid;

  assign w_opc  = in_instr[6:0];
  assign w_rd   = in_instr[11:7];
  assign w_rs1  = in_instr[19:15];
  assign w_rs2  = in_instr[24:20];
  assign w_fmt  = opc_fmt(w_opc);
  assign w_use1 = w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign w_use2 = w_fmt inside {FMT_R, FMT_S, FMT_B};
  assign w_we   = (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (w_rd != 5'd0);

  assign rf_reg_a = {1'b0, w_rs1};
  assign rf_reg_b = {1'b0, w_rs2};

`ifdef DECODE_WB_BYPASS_EN
  assign w_byp1 = wb_valid && (wb_rd == w_rs1) && (w_rs1 != 5'd0);
  assign w_byp2 = wb_valid && (wb_rd == w_rs2) && (w_rs2 != 5'd0);
  assign w_v1   = w_byp1 ? wb_data : rf_data_a;
  assign w_v2   = w_byp2 ? wb_data : rf_data_b;
`else
  // Without forwarding the busy bit clears at the retire edge, so the stall ends a cycle later.
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
  assign w_v1   = rf_data_a;
  assign w_v2   = rf_data_b;
`endif

  assign w_haz    = (w_use1 && w_busy1 && !w_byp1) || (w_use2 && w_busy2 && !w_byp2);
  assign in_ready = rst && (!r_valid || out_ready) && !w_haz && !flush;
  assign w_acc    = in_valid && in_ready;

  always_comb begin
    w_pl         = '0;
    w_pl.pc      = in_pc;
    w_pl.opcode  = w_opc;
    w_pl.funct3  = in_instr[14:12];
    w_pl.funct7  = in_instr[31:25];
    w_pl.rd      = w_rd;
    w_pl.rs1_val = w_v1;
    w_pl.rs2_val = w_v2;
    w_pl.imm     = imm_gen(in_instr, w_fmt);
    w_pl.we      = w_we;
    w_pl.illegal = (w_fmt == FMT_NONE);
  end

  scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_acc && w_we),
    .i_set_idx  (w_rd),
    .i_clr_a_en (wb_valid),
    .i_clr_a_idx(wb_rd),
    .i_clr_b_en (flush && r_valid && r_pl.we),
    .i_clr_b_idx(r_pl.rd),
    .i_q1_idx   (w_rs1),
    .i_q2_idx   (w_rs2),
    .o_q1_busy  (w_busy1),
    .o_q2_busy  (w_busy2)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pl    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_pl    <= w_pl;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pl.pc;
  assign out_opcode  = r_pl.opcode;
  assign out_funct3  = r_pl.funct3;
  assign out_funct7  = r_pl.funct7;
  assign out_rd      = r_pl.rd;
  assign out_rs1_val = r_pl.rs1_val;
  assign out_rs2_val = r_pl.rs2_val;
  assign out_imm     = r_pl.imm;
  assign out_we      = r_pl.we;
  assign out_illegal = r_pl.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; follows DECODE_WB_BYPASS_EN when defined.
module tb_decode_stage;
  localparam logic [31:0] RFA = 32'hAAAA0001;
  localparam logic [31:0] RFB = 32'hBBBB0002;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_valid, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rf_data_a, rf_data_b;
  logic [5:0]  rf_reg_a, rf_reg_b;
  logic [4:0]  wb_rd, out_rd;
`ifdef DECODE_WB_BYPASS_EN
  logic [31:0] wb_data;
`endif
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
  logic        out_we, out_illegal;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_reg_a(rf_reg_a), .rf_reg_b(rf_reg_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .wb_valid(wb_valid), .wb_rd(wb_rd),
`ifdef DECODE_WB_BYPASS_EN
    .wb_data(wb_data),
`endif
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_we(out_we), .out_illegal(out_illegal)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
    wb_valid = 1'b1; wb_rd = 5'd1; flush = 1'b1; out_ready = 1'b1;
    rf_data_a = RFA; rf_data_b = RFB;
`ifdef DECODE_WB_BYPASS_EN
    wb_data = 32'd0;
`endif
    step(); step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0h want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0h want 0", in_ready); end
    n_chk++; if (out_imm !== 32'd0) begin n_fail++; $display("FAIL rst_out_imm: got %h want 0", out_imm); end
    n_chk++; if (out_pc !== 32'd0 || out_we !== 1'b0) begin n_fail++; $display("FAIL rst_payload: pc %h we %0h want 0", out_pc, out_we); end
    rst = 1'b1; in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0h want 1", in_ready); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready: got %0h want 1", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h want 1", out_valid); end
    n_chk++; if (out_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h want 5", out_imm); end
    n_chk++; if (out_rd !== 5'd1 || out_we !== 1'b1) begin n_fail++; $display("FAIL addi_rd_we: rd %0d we %0h want 1 1", out_rd, out_we); end
    n_chk++; if (out_pc !== 32'h100 || out_rs1_val !== RFA) begin n_fail++; $display("FAIL addi_pc_rs1: pc %h rs1 %h want 100 %h", out_pc, out_rs1_val, RFA); end
    in_instr = 32'h00108133; in_pc = 32'h104;  // add x2,x1,x1
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy1_stall: got %0h want 0", in_ready); end
  endtask

  task automatic test_hazard();
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL haz_bubble: got %0h want 0", out_valid); end
    wb_valid = 1'b1; wb_rd = 5'd1;
`ifdef DECODE_WB_BYPASS_EN
    wb_data = 32'h0000_0055;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL byp_ready: got %0h want 1", in_ready); end
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_rd !== 5'd2) begin n_fail++; $display("FAIL byp_issue: valid %0h rd %0d want 1 2", out_valid, out_rd); end
    n_chk++; if (out_rs1_val !== 32'h55 || out_rs2_val !== 32'h55) begin n_fail++; $display("FAIL byp_data: %h %h want 55 55", out_rs1_val, out_rs2_val); end
`else
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wb_same_cycle_stall: got %0h want 0", in_ready); end
    step();
    wb_valid = 1'b0;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wb_next_ready: got %0h want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_rd !== 5'd2) begin n_fail++; $display("FAIL add_issue: valid %0h rd %0d want 1 2", out_valid, out_rd); end
    n_chk++; if (out_rs1_val !== RFA || out_rs2_val !== RFB) begin n_fail++; $display("FAIL add_data: %h %h want %h %h", out_rs1_val, out_rs2_val, RFA, RFB); end
`endif
    wb_valid = 1'b1; wb_rd = 5'd2;
    step();
    wb_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %0h want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h200;  // lui x5
    step();
    in_instr = 32'h00700313; in_pc = 32'h204;  // addi x6,x0,7
    #1;
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready c%0d: got %0h want 0", c, in_ready); end
      n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin n_fail++; $display("FAIL hold_pc c%0d: valid %0h pc %h want 1 200", c, out_valid, out_pc); end
      n_chk++; if (out_imm !== 32'h12345000) begin n_fail++; $display("FAIL hold_imm c%0d: got %h want 12345000", c, out_imm); end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0h want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin n_fail++; $display("FAIL b2b_pc: valid %0h pc %h want 1 204", out_valid, out_pc); end
    n_chk++; if (out_imm !== 32'd7 || out_rd !== 5'd6) begin n_fail++; $display("FAIL b2b_payload: imm %h rd %0d want 7 6", out_imm, out_rd); end
    wb_valid = 1'b1; wb_rd = 5'd5;
    step();
    wb_rd = 5'd6;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic test_set_clear_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00193; in_pc = 32'h300;  // addi x3,x0,-1
    wb_valid = 1'b1; wb_rd = 5'd3;
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL x3_issue: valid %0h imm %h want 1 ffffffff", out_valid, out_imm); end
    out_ready = 1'b1; in_instr = 32'h000183B3;  // add x7,x3,x0
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL set_wins: ready %0h want 0", in_ready); end
    out_ready = 1'b0; flush = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0h want 0", in_ready); end
    step();
    flush = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", out_valid); end
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_clr_busy3: ready %0h want 1", in_ready); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000017F; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: valid %0h ill %0h want 1 1", out_valid, out_illegal); end
    n_chk++; if (out_we !== 1'b0 || out_imm !== 32'd0) begin n_fail++; $display("FAIL ill_we_imm: we %0h imm %h want 0 0", out_we, out_imm); end
    n_chk++; if (out_rs1_val !== RFA || out_rs2_val !== RFB) begin n_fail++; $display("FAIL ill_rf: %h %h want %h %h", out_rs1_val, out_rs2_val, RFA, RFB); end
    in_instr = 32'h00010233;  // add x4,x2,x0
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_no_busy: ready %0h want 1", in_ready); end
    step();
  endtask

  task automatic test_imm();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFE002E23; in_pc = 32'h500;  // sw x0,-4(x0)
    step();
    in_instr = 32'hFE000CE3; in_pc = 32'h504;  // beq x0,x0,-8
    n_chk++; if (out_imm !== 32'hFFFFFFFC || out_we !== 1'b0) begin n_fail++; $display("FAIL s_imm: imm %h we %0h want fffffffc 0", out_imm, out_we); end
    n_chk++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL s_illegal: got %0h want 0", out_illegal); end
    step();
    in_valid = 1'b0;
    n_chk++; if (out_imm !== 32'hFFFFFFF8 || out_pc !== 32'h504) begin n_fail++; $display("FAIL b_imm: imm %h pc %h want fffffff8 504", out_imm, out_pc); end
    n_chk++; if (out_funct3 !== 3'd0 || out_opcode !== 7'h63) begin n_fail++; $display("FAIL b_fields: f3 %0h opc %h want 0 63", out_funct3, out_opcode); end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_hazard();
    test_back_to_back();
    test_set_clear_flush();
    test_illegal();
    test_imm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous reset, active-low.
REQ-004 in_valid, in_ready  in/out  1/1  fetch handshake; in_instr in 32, in_pc in 32.
REQ-005 rf_reg_a, rf_reg_b  out  6/6  register-file read addresses, {1'b0, rs1} and {1'b0, rs2}, driven combinationally from in_instr.
REQ-006 rf_data_a, rf_data_b  in  32/32  combinational register-file read data.
REQ-007 wb_valid in 1, wb_rd in 5  writeback retire notification; it clears the scoreboard.
REQ-008 flush  in  1  discards the held decoded instruction.
REQ-009 out_valid out 1, out_ready in 1  issue handshake to execute.
REQ-010 Issue payload outputs: out_pc 32, out_opcode 7, out_funct3 3, out_funct7 7, out_rd 5, out_rs1_val 32, out_rs2_val 32, out_imm 32, out_we 1, out_illegal 1.

Function
REQ-011 Accept when in_valid and in_ready; the payload SHALL be registered, giving latency 1 cycle from accept to out_valid.
REQ-012 in_ready = (!out_valid or out_ready) and !hazard and !flush.
REQ-013 Operand use: LUI/AUIPC/JAL use no source; OP-IMM/LOAD/JALR use rs1; OP/STORE/BRANCH use rs1 and rs2; any other opcode uses none and sets out_illegal=1.
REQ-014 hazard = (uses rs1 and busy[rs1]) or (uses rs2 and busy[rs2]); busy[0] SHALL always read 0.
REQ-015 Immediate: I/S/B/U/J formats per RV32I, sign-extended to 32 bits; R-type and illegal opcodes give out_imm=0.
REQ-016 out_we=1 only for OP, OP-IMM, LOAD, LUI, AUIPC, JAL or JALR with rd!=0.
REQ-017 On accept with out_we=1, busy[rd] SHALL be set.
REQ-018 On wb_valid, busy[wb_rd] SHALL be cleared.
REQ-019 A same-cycle set and clear of the same index SHALL leave the bit set.
REQ-020 out_valid SHALL hold with a stable payload until out_ready; a simultaneous issue and accept SHALL replace the payload with no bubble.
REQ-021 flush SHALL clear out_valid on the next edge and clear busy[out_rd] of the discarded entry if its out_we=1; no accept occurs that cycle.
REQ-022 An illegal instruction SHALL still be issued downstream, with out_we=0 and rf values captured.

Reset
REQ-023 While rst=0 at an edge: out_valid=0, all busy bits=0, all payload outputs=0; in_ready SHALL be 0 during reset.
REQ-024 Reset SHALL override flush, wb_valid and accept in the same cycle.

Configuration
REQ-025 Macro DECODE_WB_BYPASS_EN: when defined, add input wb_data (32 bits).
REQ-026 With DECODE_WB_BYPASS_EN, a busy source matching wb_rd with wb_valid SHALL not cause a hazard, and wb_data SHALL be captured instead of rf data.
REQ-027 Without DECODE_WB_BYPASS_EN, such a source SHALL stall until the cycle after wb_valid.

Structure
REQ-028 Package decode_pkg SHALL hold: the opcode constants, a format enum (R, I, S, B, U, J, NONE), and the decoded-payload struct.
REQ-029 Sub-module scoreboard SHALL hold the 32 busy bits, with set/clear/query ports and the set-wins rule.

Verification
REQ-030 Reset: hold rst=0 for 2 cycles -> out_valid=0, in_ready=0; release -> in_ready=1.
REQ-031 Issue addi x1,x0,5 (0x00500093) -> next cycle out_valid=1, out_imm=5, out_rd=1, out_we=1, and busy[1] is set.
REQ-032 Issue add x2,x1,x1 while busy[1]=1 -> in_ready=0; wb_valid with wb_rd=1 -> accepted one cycle later (no bypass) or the same cycle (bypass, operands = wb_data).
REQ-033 Hold out_ready=0 for 3 cycles with a new in_valid -> payload stable and in_ready=0; raise out_ready -> back-to-back issue with no bubble.
REQ-034 Same-cycle accept of a write to x3 and wb_rd=3 -> busy[3]=1; then flush -> out_valid=0 and busy[3]=0.
REQ-035 Issue opcode 0x7F -> out_illegal=1, out_we=0, out_imm=0, and no busy bit set.
